// File: rtl/dwt_fir_stage_if.sv
// Sample, control and coefficient signals of one DWT FIR stage.
// The master drives samples and coefficients; the slave is the filter stage.
interface dwt_fir_stage_if #(
    parameter int unsigned W_IN  = 9,
    parameter int unsigned C_IN  = 9,
    parameter int unsigned Y_OUT = 25,
    parameter int unsigned TAPS  = 4
);
    logic [1:0]              mode;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [W_IN-1:0]         x_in;
    logic                    coef_wr;
    logic [$clog2(TAPS)-1:0] coef_addr;
    logic [C_IN-1:0]         coef_data;
    logic                    out_valid;
    logic [Y_OUT-1:0]        y_k;

    modport master (
        output mode, flush, in_valid, x_in, coef_wr, coef_addr, coef_data,
        input  in_ready, out_valid, y_k
    );

    modport slave (
        input  mode, flush, in_valid, x_in, coef_wr, coef_addr, coef_data,
        output in_ready, out_valid, y_k
    );
endinterface

// File: rtl/dwt_fir_stage.sv
// N-tap FIR stage with runtime coefficients: bypass, filter, filter+down2 and up2+filter.
// Three register stages: delay line -> products -> sum.
module dwt_fir_stage #(
    parameter int unsigned             W_IN      = 9,
    parameter int unsigned             C_IN      = 9,
    parameter int unsigned             Y_OUT     = 25,
    parameter int unsigned             TAPS      = 4,
    parameter logic [TAPS*C_IN-1:0]    COEF_INIT = {-9'sd34, 9'sd57, 9'sd214, 9'sd123}
) (
    input logic            clk,
    input logic            rst,
    dwt_fir_stage_if.slave bus
);
    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned P     = W_IN + C_IN;
    localparam logic [AW:0] TapsW = (AW + 1)'(TAPS);

    if (Y_OUT < W_IN + C_IN + $clog2(TAPS)) begin : g_bad_width
        $error("dwt_fir_stage: Y_OUT too narrow for full-precision sum");
    end
    if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
        $error("dwt_fir_stage: TAPS must be within 2..16");
    end

    typedef enum logic [1:0] {
        ModeBypass = 2'b00,
        ModeFilter = 2'b01,
        ModeDown2  = 2'b10,
        ModeUp2    = 2'b11
    } mode_e;

    mode_e                   mode_q;
    logic                    phase_q;
    logic                    pend_q;
    logic                    v0_q;
    logic                    v1_q;
    logic                    out_valid_q;
    logic signed [W_IN-1:0]  d_q    [TAPS];
    logic signed [C_IN-1:0]  coef_q [TAPS];
    logic signed [P-1:0]     prod_q [TAPS];
    logic signed [Y_OUT-1:0] y_q;
    logic signed [Y_OUT-1:0] sum;

    logic                    in_ready;
    logic                    accept;
    logic                    inject;
    logic                    emit;
    logic signed [W_IN-1:0]  sample;

    // A pending up2 zero owns the cycle after each real sample.
    assign in_ready = !bus.flush && !pend_q;

    always_comb begin
        accept = bus.in_valid && in_ready;
        inject = pend_q && !bus.flush;
        sample = accept ? $signed(bus.x_in) : '0;
        emit   = inject || (accept && (mode_q != ModeDown2 || !phase_q));
        sum    = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + Y_OUT'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                d_q[i]    <= '0;
                prod_q[i] <= '0;
                coef_q[i] <= COEF_INIT[i*C_IN +: C_IN];
            end
            mode_q      <= mode_e'(bus.mode);
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            if (bus.coef_wr && ({1'b0, bus.coef_addr} < TapsW)) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end

            if (bus.flush) begin
                for (int i = 0; i < TAPS; i++) begin
                    d_q[i] <= '0;
                end
                phase_q <= 1'b0;
                pend_q  <= 1'b0;
                mode_q  <= mode_e'(bus.mode);
            end else if (accept || inject) begin
                d_q[0] <= sample;
                for (int i = 1; i < TAPS; i++) begin
                    d_q[i] <= d_q[i-1];
                end
                if (accept) begin
                    phase_q <= !phase_q;
                end
                pend_q <= accept && (mode_q == ModeUp2);
            end

            // Bypass routes the newest sample through tap 0 so latency matches the filter.
            for (int i = 0; i < TAPS; i++) begin
                if (mode_q == ModeBypass) begin
                    prod_q[i] <= (i == 0) ? P'(d_q[0]) : '0;
                end else begin
                    prod_q[i] <= P'(coef_q[i]) * P'(d_q[i]);
                end
            end

            v0_q        <= emit;
            v1_q        <= v0_q;
            out_valid_q <= v1_q;
            y_q         <= sum;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y_k       = y_q;
endmodule
